// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and types shared by the UART receiver files.
//   rx_state_e : one-hot receiver FSM encoding
//   rx_ctx_t   : FSM context register (state + bit-time and bit counters)
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [3:0] {
    RX_ST_IDLE  = 4'b0001,
    RX_ST_START = 4'b0010,
    RX_ST_DATA  = 4'b0100,
    RX_ST_STOP  = 4'b1000
  } rx_state_e;

  // The whole FSM context lives in one struct so a checker can bind to a
  // single signal (u_dut.ctx_q) to observe state and both counters.
  typedef struct packed {
    rx_state_e  state;
    logic [7:0] bt_cnt;
    logic [2:0] bit_cnt;
  } rx_ctx_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line,
// followed by a falling-edge detector on the synchronized value.
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset (all flops reset to line idle = 1)
//   d_i     : asynchronous serial input
//   q_o     : synchronized line (rx_s)
//   fall_o  : high while rx_s=0 and the previous rx_s was 1
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign q_o    = sync2_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Frame = start bit (0), 8 data bits MSB first,
// stop bit (1). The line is oversampled CLKS_PER_BIT times per bit and
// sampled mid-bit; framing errors and overruns are flagged.
//   CLKS_PER_BIT : clocks per serial bit (4..255)
//   clk_i        : system clock
//   rst_n_i      : asynchronous active-low reset
//   RxD_i        : asynchronous serial line, idles high
//   rd_i         : host consumed data_o (only meaningful while valid_o=1)
//   data_o       : last received byte
//   valid_o      : data_o holds an unread byte
//   frame_err_o  : last frame ended with stop bit = 0
//   overrun_o    : sticky, an unread byte was overwritten
//   RX_busy_o    : a frame is in progress (START/DATA/STOP)
//
// Host handshake: valid_o=1 means data_o holds an unread byte. The host
// acknowledges with rd_i=1 for one cycle while valid_o=1; valid_o and
// overrun_o clear on the next edge. rd_i while valid_o=0 is ignored. A byte
// completing in the same cycle as rd_i is loaded with valid_o kept at 1 and
// no overrun.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       RxD_i,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       RX_busy_o
);

  // Start is confirmed half a bit after the edge; every later sample is a
  // full bit apart, which lands them mid-bit.
  localparam logic [7:0] BT_HALF = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;

  rx_ctx_t    ctx_q;
  logic [7:0] sh_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       frame_err_q;
  logic       overrun_q;

  uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (RxD_i),
    .q_o     (rx_s),
    .fall_o  (rx_fall)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctx_q       <= '{state: RX_ST_IDLE, bt_cnt: 8'd0, bit_cnt: 3'd0};
      sh_q        <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Host read; the STOP branch below may override valid_q in the same
      // cycle when a new byte lands.
      if (rd_i && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      unique case (ctx_q.state)
        RX_ST_IDLE: begin
          if (rx_fall) begin
            ctx_q.state  <= RX_ST_START;
            ctx_q.bt_cnt <= 8'd0;
          end
        end

        RX_ST_START: begin
          if (ctx_q.bt_cnt == BT_HALF) begin
            if (!rx_s) begin
              frame_err_q   <= 1'b0;
              ctx_q.bt_cnt  <= 8'd0;
              ctx_q.bit_cnt <= 3'd0;
              ctx_q.state   <= RX_ST_DATA;
            end else begin
              // Line went back high before mid start bit: a glitch.
              ctx_q.state <= RX_ST_IDLE;
            end
          end else begin
            ctx_q.bt_cnt <= ctx_q.bt_cnt + 8'd1;
          end
        end

        RX_ST_DATA: begin
          if (ctx_q.bt_cnt == BT_LAST) begin
            sh_q         <= {sh_q[6:0], rx_s};
            ctx_q.bt_cnt <= 8'd0;
            if (ctx_q.bit_cnt == BIT_LAST) begin
              ctx_q.state <= RX_ST_STOP;
            end else begin
              ctx_q.bit_cnt <= ctx_q.bit_cnt + 3'd1;
            end
          end else begin
            ctx_q.bt_cnt <= ctx_q.bt_cnt + 8'd1;
          end
        end

        RX_ST_STOP: begin
          if (ctx_q.bt_cnt == BT_LAST) begin
            if (rx_s) begin
              data_q  <= sh_q;
              valid_q <= 1'b1;
              if (valid_q && !rd_i) begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
            ctx_q.state <= RX_ST_IDLE;
          end else begin
            ctx_q.bt_cnt <= ctx_q.bt_cnt + 8'd1;
          end
        end

        default: begin
          ctx_q.state <= RX_ST_IDLE;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign RX_busy_o   = (ctx_q.state != RX_ST_IDLE);

endmodule
